// File: rtl/lsq_store_buffer_pkg.sv
// Shared LSU store-queue definitions.
//   drain_state_e : states of the committed-store drain FSM
//   stq_ptr_w()   : pointer width for a given depth (index bits plus one wrap bit)
// The entry record (addr, data, be, addr_valid) is declared in lsq_store_buffer
// because its field widths follow that module's ADDR_W / DATA_W parameters.
package lsq_store_buffer_pkg;

    typedef enum logic [0:0] {
        DRAIN_IDLE = 1'b0,
        DRAIN_REQ  = 1'b1
    } drain_state_e;

    function automatic int stq_ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lsq_store_buffer_age_prio.sv
// stq_age_prio: choose the youngest older matching store entry.
//   match_i    : entries whose address matches (any age)
//   age_mask_i : entries older than the load and still occupied
//   head_idx_i : index of the oldest entry in the queue
//   youngest_o : one-hot vector of the youngest entry in (match_i & age_mask_i),
//                all zero when there is none
// Age order is circular starting at head_idx_i, so the candidates are rotated
// so that the head lands at position 0; the highest set rotated position is
// then the youngest.
module stq_age_prio #(
    parameter int DEPTH = 16
) (
    input  logic [DEPTH-1:0]         match_i,
    input  logic [DEPTH-1:0]         age_mask_i,
    input  logic [$clog2(DEPTH)-1:0] head_idx_i,
    output logic [DEPTH-1:0]         youngest_o
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] cand;
    logic [DEPTH-1:0] rot;
    logic [IDX_W-1:0] sel;
    logic             found;

    always_comb begin
        cand       = match_i & age_mask_i;
        rot        = '0;
        sel        = '0;
        found      = 1'b0;
        youngest_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rot[i] = cand[head_idx_i + IDX_W'(i)];
        end
        // Later (younger) positions overwrite earlier ones.
        for (int i = 0; i < DEPTH; i++) begin
            if (rot[i]) begin
                sel   = IDX_W'(i);
                found = 1'b1;
            end
        end
        youngest_o[head_idx_i + sel] = found;
    end

endmodule

// File: rtl/lsq_store_buffer.sv
// lsq_store_buffer: LSU store queue.
//   Allocation (alloc_valid_i -> alloc_id_o, full_o, count_o), execute
//   (st_exec_*), registered store-to-load forwarding lookup (ld_* -> fwd_*),
//   in-order commit (commit_i), committed-store drain to memory
//   (mem_st_valid_o / mem_st_ready_i / mem_st_*_o) and flush of uncommitted
//   stores (recover_i). drain_state_o exposes the drain FSM state.
// Handshake: a drain beat transfers on a cycle where mem_st_valid_o and
//   mem_st_ready_i are both high; while valid is high and ready is low the
//   payload is held stable, and valid never drops without a transfer
//   (except on reset).
// Build option: STQ_PARTIAL_MERGE_EN defined assembles each load byte from
//   the youngest older store enabling that byte; undefined considers only the
//   single youngest older matching store.
module lsq_store_buffer
    import lsq_store_buffer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     recover_i,
    input  logic                     alloc_valid_i,
    output logic [$clog2(DEPTH):0]   alloc_id_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   count_o,
    input  logic                     st_exec_valid_i,
    input  logic [$clog2(DEPTH):0]   st_exec_id_i,
    input  logic [ADDR_W-1:0]        st_addr_i,
    input  logic [DATA_W-1:0]        st_data_i,
    input  logic [DATA_W/8-1:0]      st_be_i,
    input  logic                     ld_valid_i,
    input  logic [ADDR_W-1:0]        ld_addr_i,
    input  logic [DATA_W/8-1:0]      ld_be_i,
    input  logic [$clog2(DEPTH):0]   ld_st_tail_i,
    output logic                     fwd_valid_o,
    output logic                     fwd_hit_o,
    output logic                     fwd_replay_o,
    output logic [DATA_W-1:0]        fwd_data_o,
    input  logic                     commit_i,
    output logic                     mem_st_valid_o,
    input  logic                     mem_st_ready_i,
    output logic [ADDR_W-1:0]        mem_st_addr_o,
    output logic [DATA_W-1:0]        mem_st_data_o,
    output logic [DATA_W/8-1:0]      mem_st_be_o,
    output drain_state_e             drain_state_o
);
    localparam int PTR_W = stq_ptr_w(DEPTH);
    localparam int IDX_W = PTR_W - 1;
    localparam int BE_W  = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [BE_W-1:0]   be;
        logic              addr_valid;
    } stq_entry_t;

    stq_entry_t       entry_q [DEPTH];
    stq_entry_t       entry_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, commit_q, commit_d, tail_q, tail_d;
    drain_state_e     state_q, state_d;
    logic             fwd_valid_q, fwd_valid_d, fwd_hit_q, fwd_hit_d;
    logic             fwd_replay_q, fwd_replay_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    logic [PTR_W-1:0] count;
    logic [IDX_W-1:0] head_idx;
    logic             full, alloc_fire, commit_fire, drain_fire;

    assign head_idx    = head_q[IDX_W-1:0];
    assign count       = tail_q - head_q;
    assign full        = (tail_q[IDX_W-1:0] == head_q[IDX_W-1:0]) && (tail_q[IDX_W] != head_q[IDX_W]);
    // Recovery wins over a same-cycle allocation.
    assign alloc_fire  = alloc_valid_i && !full && !recover_i;
    assign commit_fire = commit_i && (commit_q != tail_q);
    assign drain_fire  = (state_q == DRAIN_REQ) && mem_st_ready_i;

    // Pointers, entry updates and drain FSM.
    always_comb begin
        entry_d  = entry_q;
        head_d   = head_q + PTR_W'(drain_fire);
        commit_d = commit_q + PTR_W'(commit_fire);
        tail_d   = tail_q;
        state_d  = state_q;

        // A store committed in the same cycle as recovery is kept.
        if (recover_i) begin
            tail_d = commit_d;
        end else if (alloc_fire) begin
            tail_d = tail_q + PTR_W'(1);
            entry_d[tail_q[IDX_W-1:0]].addr_valid = 1'b0;
        end

        if (st_exec_valid_i) begin
            entry_d[st_exec_id_i[IDX_W-1:0]] = '{addr: st_addr_i, data: st_data_i,
                                                 be: st_be_i, addr_valid: 1'b1};
        end

        case (state_q)
            DRAIN_IDLE: if (head_q != commit_q) state_d = DRAIN_REQ;
            // Looking at commit_d keeps the drain back-to-back when a commit
            // lands on the same edge as the last accept.
            DRAIN_REQ:  if (mem_st_ready_i && head_d == commit_d) state_d = DRAIN_IDLE;
            default:    state_d = DRAIN_IDLE;
        endcase
    end

    // Lookup: an entry is a candidate when it is occupied and older than the load.
    logic [DEPTH-1:0] age_mask, raw_match;
    logic [DATA_W-1:0] lk_data, be_mask;
    logic             lk_any, lk_full;

    always_comb begin
        logic [PTR_W-1:0] n_older;
        logic [IDX_W-1:0] rel;
        n_older   = ld_st_tail_i - head_q;
        age_mask  = '0;
        raw_match = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rel          = IDX_W'(i) - head_idx;
            age_mask[i]  = ({1'b0, rel} < n_older) && ({1'b0, rel} < count);
            raw_match[i] = entry_q[i].addr_valid && (entry_q[i].addr == ld_addr_i);
        end
        for (int b = 0; b < BE_W; b++) begin
            be_mask[b*8 +: 8] = {8{ld_be_i[b]}};
        end
    end

`ifdef STQ_PARTIAL_MERGE_EN
    logic [BE_W-1:0][DEPTH-1:0] byte_match;
    logic [BE_W-1:0][DEPTH-1:0] byte_sel;
    logic [BE_W-1:0]            lk_cov;

    always_comb begin
        for (int b = 0; b < BE_W; b++) begin
            for (int i = 0; i < DEPTH; i++) begin
                byte_match[b][i] = raw_match[i] && entry_q[i].be[b];
            end
        end
    end

    for (genvar b = 0; b < BE_W; b++) begin : g_byte_prio
        stq_age_prio #(.DEPTH(DEPTH)) u_prio (
            .match_i    (byte_match[b]),
            .age_mask_i (age_mask),
            .head_idx_i (head_idx),
            .youngest_o (byte_sel[b])
        );
    end

    always_comb begin
        lk_cov  = '0;
        lk_data = '0;
        for (int b = 0; b < BE_W; b++) begin
            lk_cov[b] = |byte_sel[b];
            for (int i = 0; i < DEPTH; i++) begin
                if (byte_sel[b][i]) lk_data[b*8 +: 8] = entry_q[i].data[b*8 +: 8];
            end
        end
        lk_any  = |(lk_cov & ld_be_i);
        lk_full = (lk_cov & ld_be_i) == ld_be_i;
    end
`else
    logic [DEPTH-1:0] sel;
    logic [BE_W-1:0]  sel_be;

    stq_age_prio #(.DEPTH(DEPTH)) u_prio (
        .match_i    (raw_match),
        .age_mask_i (age_mask),
        .head_idx_i (head_idx),
        .youngest_o (sel)
    );

    always_comb begin
        sel_be  = '0;
        lk_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (sel[i]) begin
                sel_be  = entry_q[i].be;
                lk_data = entry_q[i].data;
            end
        end
        lk_any  = |sel;
        lk_full = (sel_be & ld_be_i) == ld_be_i;
    end
`endif

    // Data is only returned on a full hit; a replaying load discards it anyway.
    always_comb begin
        fwd_valid_d  = ld_valid_i;
        fwd_hit_d    = ld_valid_i && lk_any && lk_full;
        fwd_replay_d = ld_valid_i && lk_any && !lk_full;
        fwd_data_d   = fwd_hit_d ? (lk_data & be_mask) : '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) entry_q[i] <= '0;
            head_q       <= '0;
            commit_q     <= '0;
            tail_q       <= '0;
            state_q      <= DRAIN_IDLE;
            fwd_valid_q  <= 1'b0;
            fwd_hit_q    <= 1'b0;
            fwd_replay_q <= 1'b0;
            fwd_data_q   <= '0;
        end else begin
            entry_q      <= entry_d;
            head_q       <= head_d;
            commit_q     <= commit_d;
            tail_q       <= tail_d;
            state_q      <= state_d;
            fwd_valid_q  <= fwd_valid_d;
            fwd_hit_q    <= fwd_hit_d;
            fwd_replay_q <= fwd_replay_d;
            fwd_data_q   <= fwd_data_d;
        end
    end

    assign alloc_id_o     = tail_q;
    assign full_o         = full;
    assign count_o        = count;
    assign fwd_valid_o    = fwd_valid_q;
    assign fwd_hit_o      = fwd_hit_q;
    assign fwd_replay_o   = fwd_replay_q;
    assign fwd_data_o     = fwd_data_q;
    assign mem_st_valid_o = (state_q == DRAIN_REQ);
    assign mem_st_addr_o  = mem_st_valid_o ? entry_q[head_idx].addr : '0;
    assign mem_st_data_o  = mem_st_valid_o ? entry_q[head_idx].data : '0;
    assign mem_st_be_o    = mem_st_valid_o ? entry_q[head_idx].be   : '0;
    assign drain_state_o  = state_q;

endmodule

// File: tb/tb_lsq_store_buffer.sv
module tb_lsq_store_buffer;
    import lsq_store_buffer_pkg::*;

`ifdef STQ_PARTIAL_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        recover_i = 0, alloc_valid_i = 0, st_exec_valid_i = 0;
    logic [4:0]  alloc_id_o, count_o, st_exec_id_i = '0, ld_st_tail_i = '0;
    logic        full_o;
    logic [31:0] st_addr_i = '0, st_data_i = '0, ld_addr_i = '0;
    logic [3:0]  st_be_i = '0, ld_be_i = '0;
    logic        ld_valid_i = 0, commit_i = 0, mem_st_ready_i = 0;
    logic        fwd_valid_o, fwd_hit_o, fwd_replay_o, mem_st_valid_o;
    logic [31:0] fwd_data_o, mem_st_addr_o, mem_st_data_o;
    logic [3:0]  mem_st_be_o;
    drain_state_e drain_state_o;

    lsq_store_buffer dut (
        .clk(clk), .reset(reset), .recover_i(recover_i),
        .alloc_valid_i(alloc_valid_i), .alloc_id_o(alloc_id_o), .full_o(full_o),
        .count_o(count_o), .st_exec_valid_i(st_exec_valid_i), .st_exec_id_i(st_exec_id_i),
        .st_addr_i(st_addr_i), .st_data_i(st_data_i), .st_be_i(st_be_i),
        .ld_valid_i(ld_valid_i), .ld_addr_i(ld_addr_i), .ld_be_i(ld_be_i),
        .ld_st_tail_i(ld_st_tail_i), .fwd_valid_o(fwd_valid_o), .fwd_hit_o(fwd_hit_o),
        .fwd_replay_o(fwd_replay_o), .fwd_data_o(fwd_data_o), .commit_i(commit_i),
        .mem_st_valid_o(mem_st_valid_o), .mem_st_ready_i(mem_st_ready_i),
        .mem_st_addr_o(mem_st_addr_o), .mem_st_data_o(mem_st_data_o),
        .mem_st_be_o(mem_st_be_o), .drain_state_o(drain_state_o)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // scoreboard state
    int          n_vec = 0;
    int          n_miss = 0;
    int          drained = 0;
    int          m_commit = 0;
    logic [33:0] ld_exp_q[$];   // {hit, replay, data}
    logic [67:0] st_exp_q[$];   // {addr, data, be}
    logic [31:0] m_addr [16];
    logic [31:0] m_data [16];
    logic [3:0]  m_be   [16];

    task automatic check_eq(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // monitor: responses sampled on the falling edge
    always @(negedge clk) begin
        if (!reset) begin
            if (fwd_valid_o) begin
                if (ld_exp_q.size() == 0) begin
                    check_eq("fwd_unexpected", 1, 0);
                end else begin
                    logic [33:0] e;
                    e = ld_exp_q.pop_front();
                    check_eq("fwd_hit", fwd_hit_o, e[33]);
                    check_eq("fwd_replay", fwd_replay_o, e[32]);
                    check_eq("fwd_data", fwd_data_o, e[31:0]);
                end
            end
            if (mem_st_valid_o && mem_st_ready_i) begin
                drained++;
                if (st_exp_q.size() == 0) begin
                    check_eq("drain_unexpected", 1, 0);
                end else begin
                    logic [67:0] s;
                    s = st_exp_q.pop_front();
                    check_eq("drain_payload", {mem_st_addr_o, mem_st_data_o, mem_st_be_o}, s);
                end
            end
        end
    end

    // driver tasks: inputs change 1 time unit after the rising edge
    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
        m_commit = 0;
        drained = 0;
    endtask

    task automatic do_alloc(input logic [4:0] exp_id);
        alloc_valid_i = 1'b1;
        @(negedge clk);
        check_eq("alloc_id", alloc_id_o, exp_id);
        step();
        alloc_valid_i = 1'b0;
    endtask

    task automatic do_exec(input logic [4:0] id, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] be);
        st_exec_valid_i = 1'b1; st_exec_id_i = id;
        st_addr_i = a; st_data_i = d; st_be_i = be;
        m_addr[id[3:0]] = a; m_data[id[3:0]] = d; m_be[id[3:0]] = be;
        step();
        st_exec_valid_i = 1'b0;
    endtask

    task automatic do_load(input logic [31:0] a, input logic [3:0] be, input logic [4:0] tail,
                           input logic hit, input logic replay, input logic [31:0] d);
        ld_valid_i = 1'b1; ld_addr_i = a; ld_be_i = be; ld_st_tail_i = tail;
        ld_exp_q.push_back({hit, replay, d});
        step();
        ld_valid_i = 1'b0;
    endtask

    task automatic do_commit();
        int k;
        k = m_commit % 16;
        commit_i = 1'b1;
        st_exp_q.push_back({m_addr[k], m_data[k], m_be[k]});
        m_commit++;
        step();
        commit_i = 1'b0;
    endtask

    initial begin
        logic [31:0] d0, d1, d2, d3, d4;

        // reset state
        step();
        @(negedge clk);
        check_eq("rst_full", full_o, 0);
        check_eq("rst_count", count_o, 0);
        check_eq("rst_alloc_id", alloc_id_o, 0);
        check_eq("rst_mem_valid", mem_st_valid_o, 0);
        check_eq("rst_mem_addr", mem_st_addr_o, 0);
        check_eq("rst_fwd_valid", fwd_valid_o, 0);
        check_eq("rst_fwd_data", fwd_data_o, 0);
        check_eq("rst_state", drain_state_o, DRAIN_IDLE);
        do_reset();

        // fill the queue, then one ignored allocation
        for (int i = 0; i < 16; i++) do_alloc(5'(i));
        @(negedge clk);
        check_eq("full_after_16", full_o, 1);
        check_eq("count_16", count_o, 16);
        do_alloc(5'd16);
        @(negedge clk);
        check_eq("count_stays_16", count_o, 16);
        check_eq("alloc_id_stays", alloc_id_o, 16);
        step();

        // simple forwarding
        do_exec(5'd0, 32'h100, 32'h1122_3344, 4'b1111);
        do_load(32'h100, 4'b1111, 5'd1, 1, 0, 32'h1122_3344);
        do_load(32'h100, 4'b1111, 5'd0, 0, 0, 32'h0);        // store not older

        // execute and lookup in the same cycle: lookup misses
        st_exec_valid_i = 1'b1; st_exec_id_i = 5'd1;
        st_addr_i = 32'h200; st_data_i = 32'h9988_7766; st_be_i = 4'b1111;
        m_addr[1] = 32'h200; m_data[1] = 32'h9988_7766; m_be[1] = 4'b1111;
        ld_valid_i = 1'b1; ld_addr_i = 32'h200; ld_be_i = 4'b1111; ld_st_tail_i = 5'd2;
        ld_exp_q.push_back({1'b0, 1'b0, 32'h0});
        step();
        st_exec_valid_i = 1'b0; ld_valid_i = 1'b0;
        do_load(32'h200, 4'b1111, 5'd2, 1, 0, 32'h9988_7766);

        // partial stores to the same word
        do_exec(5'd2, 32'h300, 32'h0000_AABB, 4'b0011);
        do_exec(5'd3, 32'h300, 32'hCCDD_0000, 4'b1100);
        do_load(32'h300, 4'b1111, 5'd4, MERGE, !MERGE, MERGE ? 32'hCCDD_AABB : 32'h0);
        do_load(32'h300, 4'b0001, 5'd4, MERGE, !MERGE, MERGE ? 32'h0000_00BB : 32'h0);
        do_load(32'h300, 4'b1100, 5'd4, 1, 0, 32'hCCDD_0000);
        do_load(32'h300, 4'b1111, 5'd3, 0, 1, 32'h0);
        do_load(32'h300, 4'b0011, 5'd3, 1, 0, 32'h0000_AABB);
        do_exec(5'd4, 32'h300, 32'h5566_7788, 4'b1111);
        do_load(32'h300, 4'b1111, 5'd5, 1, 0, 32'h5566_7788);

        // commit three with memory stalled, payload must hold
        do_commit(); do_commit(); do_commit();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("stall_valid", mem_st_valid_o, 1);
            check_eq("stall_payload", {mem_st_addr_o, mem_st_data_o, mem_st_be_o}, st_exp_q[0]);
            step();
        end
        do_load(32'h100, 4'b1111, 5'd1, 1, 0, 32'h1122_3344);  // draining store still visible
        mem_st_ready_i = 1'b1;
        drained = 0;
        step(); step(); step();
        @(negedge clk);
        check_eq("drain_b2b_count", drained, 3);
        check_eq("drain_done_valid", mem_st_valid_o, 0);
        check_eq("drain_done_state", drain_state_o, DRAIN_IDLE);
        check_eq("count_after_drain", count_o, 13);
        step();
        mem_st_ready_i = 1'b0;

        // recovery flushes uncommitted entries
        do_reset();
        d0 = $urandom; d1 = $urandom; d2 = $urandom; d3 = $urandom; d4 = $urandom;
        for (int i = 0; i < 5; i++) do_alloc(5'(i));
        do_exec(5'd0, 32'h400, d0, 4'b1111);
        do_exec(5'd1, 32'h500, d1, 4'b1111);
        do_exec(5'd2, 32'h400, d2, 4'b1111);
        do_exec(5'd3, 32'h400, d3, 4'b1111);
        do_exec(5'd4, 32'h400, d4, 4'b1111);
        do_commit(); do_commit();
        recover_i = 1'b1; alloc_valid_i = 1'b1;   // allocation is dropped
        step();
        recover_i = 1'b0; alloc_valid_i = 1'b0;
        @(negedge clk);
        check_eq("recover_count", count_o, 2);
        check_eq("recover_tail", alloc_id_o, 2);
        step();
        do_load(32'h400, 4'b1111, 5'd5, 1, 0, d0);
        do_load(32'h500, 4'b1111, 5'd5, 1, 0, d1);
        mem_st_ready_i = 1'b1;
        drained = 0;
        repeat ($urandom_range(3, 5)) step();
        @(negedge clk);
        check_eq("recover_drained", drained, 2);
        check_eq("recover_empty", count_o, 0);
        step();
        mem_st_ready_i = 1'b0;

        // asynchronous reset during a stalled drain
        do_reset();
        do_alloc(5'd0);
        do_exec(5'd0, 32'h600, 32'hDEAD_BEEF, 4'b0101);
        do_commit();
        step();
        @(negedge clk);
        check_eq("pre_reset_valid", mem_st_valid_o, 1);
        #2 reset = 1'b1;
        #1;
        check_eq("async_rst_valid", mem_st_valid_o, 0);
        check_eq("async_rst_count", count_o, 0);
        check_eq("async_rst_tail", alloc_id_o, 0);
        check_eq("async_rst_state", drain_state_o, DRAIN_IDLE);
        st_exp_q.delete();
        step();
        reset = 1'b0;
        step(); step();

        check_eq("ld_queue_empty", ld_exp_q.size(), 0);
        check_eq("st_queue_empty", st_exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
